// File: rtl/btn_event_counter.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_counter
//  Purpose  : Multi-channel push-button synchroniser, debouncer and
//             press/release event counter with wrap or saturate counters.
//  Revision : 1.0  initial release
// ============================================================================
module btn_event_counter #(
    parameter int NUM_CH          = 4,
    parameter int COUNT_WIDTH     = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SYNC_STAGES     = 2,
    parameter int SATURATE        = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             btn_i,
    input  logic [NUM_CH-1:0]             dir_i,
    input  logic                          clear_i,
    output logic [NUM_CH*COUNT_WIDTH-1:0] count_o,
    output logic [NUM_CH-1:0]             pressed_o,
    output logic [NUM_CH-1:0]             press_pulse_o,
    output logic [NUM_CH-1:0]             release_pulse_o,
    output logic [NUM_CH-1:0]             limit_pulse_o
);

    localparam int                     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]        DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]        DB_ONE  = DB_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s_w;
            state_t                 state_q, state_d;
            logic [DB_W-1:0]        db_q, db_d;
            logic                   press_evt_d, press_evt_q;
            logic                   rel_evt_d, rel_evt_q;
            logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
            logic                   lim_d;
            logic                   pressed_q, press_pulse_q, release_pulse_q, limit_pulse_q;

            assign s_w = sync_q[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i[i]};
                end
            end

            always_comb begin
                state_d     = state_q;
                db_d        = db_q;
                press_evt_d = 1'b0;
                rel_evt_d   = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (s_w) begin
                            state_d = ST_PRESS_DB;
                            db_d    = DB_ONE;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (!s_w) begin
                            state_d = ST_IDLE;
                            db_d    = '0;
                        end else if (db_q == DB_MAX) begin
                            state_d     = ST_HELD;
                            press_evt_d = 1'b1;
                        end else begin
                            db_d = db_q + DB_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (!s_w) begin
                            state_d = ST_REL_DB;
                            db_d    = DB_ONE;
                        end
                    end
                    ST_REL_DB: begin
                        if (s_w) begin
                            state_d = ST_HELD;
                        end else if (db_q == DB_MAX) begin
                            state_d   = ST_IDLE;
                            rel_evt_d = 1'b1;
                        end else begin
                            db_d = db_q + DB_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        db_d    = '0;
                    end
                endcase
            end

            // Counter update happens on the cycle the release event is presented,
            // so dir is sampled alongside it and clear simply overrides the result.
            always_comb begin
                cnt_d = cnt_q;
                lim_d = 1'b0;
                if (rel_evt_q) begin
                    if (!dir_i[i]) begin
                        if (cnt_q == CNT_MAX) begin
                            lim_d = 1'b1;
                            cnt_d = (SATURATE != 0) ? cnt_q : '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            lim_d = 1'b1;
                            cnt_d = (SATURATE != 0) ? cnt_q : CNT_MAX;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                if (clear_i) begin
                    cnt_d = '0;
                    lim_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q         <= ST_IDLE;
                    db_q            <= '0;
                    press_evt_q     <= 1'b0;
                    rel_evt_q       <= 1'b0;
                    cnt_q           <= '0;
                    pressed_q       <= 1'b0;
                    press_pulse_q   <= 1'b0;
                    release_pulse_q <= 1'b0;
                    limit_pulse_q   <= 1'b0;
                end else begin
                    state_q         <= state_d;
                    db_q            <= db_d;
                    press_evt_q     <= press_evt_d;
                    rel_evt_q       <= rel_evt_d;
                    cnt_q           <= cnt_d;
                    pressed_q       <= (state_q == ST_HELD) || (state_q == ST_REL_DB);
                    press_pulse_q   <= press_evt_q;
                    release_pulse_q <= rel_evt_q;
                    limit_pulse_q   <= lim_d;
                end
            end

            assign count_o[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
            assign pressed_o[i]       = pressed_q;
            assign press_pulse_o[i]   = press_pulse_q;
            assign release_pulse_o[i] = release_pulse_q;
            assign limit_pulse_o[i]   = limit_pulse_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_event_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_event_counter
//  Purpose  : Directed scoreboard bench for btn_event_counter, one wrapping
//             and one saturating instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_event_counter;

    localparam int NCH = 2;
    localparam int CW  = 3;
    localparam int DBC = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + DBC + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, rst_b, clr_a, clr_b;
    logic [NCH-1:0]    btn_a, dir_a, btn_b, dir_b;
    logic [NCH*CW-1:0] cnt_a, cnt_b;
    logic [NCH-1:0]    prs_a, pp_a, rp_a, lp_a;
    logic [NCH-1:0]    prs_b, pp_b, rp_b, lp_b;

    btn_event_counter #(.NUM_CH(NCH), .COUNT_WIDTH(CW), .DEBOUNCE_CYCLES(DBC),
                        .SYNC_STAGES(SS), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(rst_a), .btn_i(btn_a), .dir_i(dir_a), .clear_i(clr_a),
        .count_o(cnt_a), .pressed_o(prs_a), .press_pulse_o(pp_a),
        .release_pulse_o(rp_a), .limit_pulse_o(lp_a));

    btn_event_counter #(.NUM_CH(NCH), .COUNT_WIDTH(CW), .DEBOUNCE_CYCLES(DBC),
                        .SYNC_STAGES(SS), .SATURATE(1)) u_sat (
        .clk(clk), .reset(rst_b), .btn_i(btn_b), .dir_i(dir_b), .clear_i(clr_b),
        .count_o(cnt_b), .pressed_o(prs_b), .press_pulse_o(pp_b),
        .release_pulse_o(rp_b), .limit_pulse_o(lp_b));

    typedef struct {
        int           ch;
        logic [CW-1:0] cnt;
        logic         lim;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   model_a[NCH];
    int   model_b[NCH];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one counter update at a validated release.
    task automatic model_step(input int cur, input bit dn, input bit sat,
                              output int nxt, output bit lim);
        int max = (1 << CW) - 1;
        lim = 1'b0;
        if (!dn) begin
            if (cur == max) begin lim = 1'b1; nxt = sat ? max : 0; end
            else nxt = cur + 1;
        end else begin
            if (cur == 0) begin lim = 1'b1; nxt = sat ? 0 : max; end
            else nxt = cur - 1;
        end
    endtask

    task automatic push_exp(input bit b, input int ch, input int cnt, input bit lim);
        exp_t e;
        e.ch  = ch;
        e.cnt = CW'(cnt);
        e.lim = lim;
        if (b) q_b.push_back(e); else q_a.push_back(e);
    endtask

    // Scoreboard consumer: every release strobe must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (rp_a[ch] === 1'b1) begin
                    vectors++;
                    assert (q_a.size() != 0) else begin
                        miscompares++;
                        $error("FAIL rel_unexpected_a ch%0d: observed release, expected none", ch);
                    end
                    if (q_a.size() != 0) begin
                        exp_t e;
                        e = q_a.pop_front();
                        check($sformatf("sb_ch_a%0d", ch), ch, e.ch);
                        check($sformatf("sb_cnt_a%0d", ch), cnt_a[ch*CW +: CW], e.cnt);
                        check($sformatf("sb_lim_a%0d", ch), lp_a[ch], e.lim);
                    end
                end
                if (rp_b[ch] === 1'b1) begin
                    vectors++;
                    assert (q_b.size() != 0) else begin
                        miscompares++;
                        $error("FAIL rel_unexpected_b ch%0d: observed release, expected none", ch);
                    end
                    if (q_b.size() != 0) begin
                        exp_t e;
                        e = q_b.pop_front();
                        check($sformatf("sb_ch_b%0d", ch), ch, e.ch);
                        check($sformatf("sb_cnt_b%0d", ch), cnt_b[ch*CW +: CW], e.cnt);
                        check($sformatf("sb_lim_b%0d", ch), lp_b[ch], e.lim);
                    end
                end
            end
            check("lim_without_rel_a", lp_a & ~rp_a, 0);
            check("lim_without_rel_b", lp_b & ~rp_b, 0);
        end
    end

    // Edges from the first sampling edge until the chosen strobe is seen; -1 on timeout.
    task automatic measure(input bit b, input int ch, input bit rel, output int lat);
        logic [NCH-1:0] v;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            v = rel ? (b ? rp_b : rp_a) : (b ? pp_b : pp_a);
            if (v[ch] === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic press(input bit b, input int ch, input bit dn);
        int nxt;
        bit lim;
        if (b) begin
            model_step(model_b[ch], dn, 1'b1, nxt, lim);
            model_b[ch] = nxt;
        end else begin
            model_step(model_a[ch], dn, 1'b0, nxt, lim);
            model_a[ch] = nxt;
        end
        push_exp(b, ch, nxt, lim);
        @(negedge clk);
        if (b) begin dir_b[ch] = dn; btn_b[ch] = 1'b1; end
        else   begin dir_a[ch] = dn; btn_a[ch] = 1'b1; end
        repeat (12) @(negedge clk);
        if (b) btn_b[ch] = 1'b0; else btn_a[ch] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [7:0]  pat;

        rst_a = 1'b1; rst_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        btn_a = '0; dir_a = '0; btn_b = '0; dir_b = '0;
        for (int c = 0; c < NCH; c++) begin model_a[c] = 0; model_b[c] = 0; end
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("rst_count_a", cnt_a, 0);
        check("rst_count_b", cnt_b, 0);
        check("rst_pressed_a", prs_a, 0);
        check("rst_pulses_a", {pp_a, rp_a, lp_a}, 0);
        check("rst_pulses_b", {prs_b, pp_b, rp_b, lp_b}, 0);
        mon_en = 1'b1;

        // Clean press on ch0 with latency measurement
        model_a[0] = 1;
        push_exp(1'b0, 0, 1, 1'b0);
        dir_a[0] = 1'b0;
        btn_a[0] = 1'b1;
        measure(1'b0, 0, 1'b0, lat);
        check("press_latency", lat, LAT);
        @(negedge clk);
        check("press_pulse_width", pp_a[0], 0);
        check("pressed_held", prs_a[0], 1);
        repeat (10) @(negedge clk);
        btn_a[0] = 1'b0;
        measure(1'b0, 0, 1'b1, lat);
        check("release_latency", lat, LAT);
        @(negedge clk);
        check("release_pulse_width", rp_a[0], 0);
        check("pressed_after_rel", prs_a[0], 0);
        check("ch1_untouched", cnt_a[CW +: CW], 0);

        // Bounce rejection
        pat  = 8'b0111_0111;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            btn_a[0] = pat[k];
            @(negedge clk);
            if (pp_a[0] === 1'b1 || prs_a[0] === 1'b1) seen = 1'b1;
        end
        btn_a[0] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (pp_a[0] === 1'b1 || prs_a[0] === 1'b1) seen = 1'b1;
        end
        check("bounce_no_press", seen, 0);
        check("bounce_count", cnt_a[0 +: CW], model_a[0]);

        // Wrap on ch1: eight ups then one down
        for (int n = 0; n < 8; n++) press(1'b0, 1, 1'b0);
        check("wrap_count_zero", cnt_a[CW +: CW], 0);
        press(1'b0, 1, 1'b1);
        check("wrap_down_count", cnt_a[CW +: CW], 7);

        // Clear coincident with releases on both channels (ch1 would wrap)
        dir_a = 2'b00;
        model_a[0] = 0; model_a[1] = 0;
        push_exp(1'b0, 0, 0, 1'b0);
        push_exp(1'b0, 1, 0, 1'b0);
        @(negedge clk);
        btn_a = 2'b11;
        repeat (12) @(negedge clk);
        btn_a = 2'b00;
        repeat (LAT) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("clear_rel_pulses", rp_a, 2'b11);
        check("clear_no_limit", lp_a, 2'b00);
        check("clear_counts", cnt_a, 0);

        // Reset while ch0 is held
        @(negedge clk);
        btn_a[0] = 1'b1;
        measure(1'b0, 0, 1'b0, lat);
        check("pre_reset_press_latency", lat, LAT);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_count", cnt_a, 0);
        check("midrst_flags", {prs_a, pp_a, rp_a, lp_a}, 0);
        rst_a = 1'b0;
        measure(1'b0, 0, 1'b0, lat);
        check("requalify_latency", lat, LAT);
        model_a[0] = 1;
        push_exp(1'b0, 0, 1, 1'b0);
        repeat (4) @(negedge clk);
        btn_a[0] = 1'b0;
        measure(1'b0, 0, 1'b1, lat);
        check("post_reset_rel_latency", lat, LAT);
        @(negedge clk);
        check("post_reset_count", cnt_a[0 +: CW], 1);

        // Saturating instance: clamp at zero, then at max
        press(1'b1, 0, 1'b1);
        check("sat_floor", cnt_b[0 +: CW], 0);
        for (int n = 0; n < 9; n++) press(1'b1, 0, 1'b0);
        check("sat_ceiling", cnt_b[0 +: CW], 7);
        check("sat_ch1_untouched", cnt_b[CW +: CW], 0);

        repeat (20) @(negedge clk);
        check("sb_drained_a", q_a.size(), 0);
        check("sb_drained_b", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
